// File: rtl/lcd_scan.sv
// rtl/lcd_scan.sv - framebuffer scan controller for a 4-bit STN panel (optional LCD_INVERT_EN)
module lcd_scan #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        pixelclk,
    output logic [13:0] pixeladdr,
    input  logic        pixel,
    output logic [3:0]  d,
    output logic        cp,
    output logic        lp,
    output logic        flm,
    output logic        m,
    output logic        frame_done
);
    // Column offset of the last nibble and base address of the last line.
    localparam logic [13:0] LAST_COL  = 14'(WIDTH - 4);
    localparam logic [13:0] LAST_BASE = 14'((HEIGHT - 1) * WIDTH);
    localparam logic [13:0] LINE_STEP = 14'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  phase;
    logic [13:0] col;        // 4 * nibble index within the line
    logic [13:0] line_base;  // line * WIDTH, stepped by WIDTH each line
    logic [2:0]  shreg;      // first three pixels of the nibble, leftmost in bit 2
    logic [3:0]  d_reg;
    logic [3:0]  nib_load;
    logic        m_reg;
    logic        last_nib;
    logic        last_line;

    assign last_nib  = (col == LAST_COL);
    assign last_line = (line_base == LAST_BASE);

`ifdef LCD_INVERT_EN
    assign nib_load = ~{shreg, pixel};
`else
    assign nib_load = {shreg, pixel};
`endif

    // State register; reset forces IDLE regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: dropping en returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = NIB;
            NIB: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (phase == 3'd7 && last_nib) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (phase == 3'd7) begin
                    state_next = NIB;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase, column and line-base counters; cleared whenever the scan is not running.
    always_ff @(posedge clk) begin
        if (reset || !en || state == IDLE) begin
            phase     <= 3'd0;
            col       <= 14'd0;
            line_base <= 14'd0;
        end else begin
            phase <= phase + 3'd1;
            if (phase == 3'd7) begin
                if (state == NIB) begin
                    col <= last_nib ? 14'd0 : col + 14'd4;
                end else begin
                    col       <= 14'd0;
                    line_base <= last_line ? 14'd0 : line_base + LINE_STEP;
                end
            end
        end
    end

    // Pixel capture: hub data arrives one clk after its address, so phases 1..4 see pixels 0..3.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            shreg <= 3'd0;
            d_reg <= 4'd0;
        end else if (state == NIB) begin
            case (phase)
                3'd1:    shreg[2] <= pixel;
                3'd2:    shreg[1] <= pixel;
                3'd3:    shreg[0] <= pixel;
                3'd4:    d_reg    <= nib_load;
                default: ;
            endcase
        end
    end

    // AC-drive alternation flips once per frame and only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg <= 1'b0;
        end else if (en && frame_done) begin
            m_reg <= ~m_reg;
        end
    end

    // Panel and fetch outputs decoded from registered state only; no input reaches an output.
    always_comb begin
        pixelclk   = 1'b0;
        pixeladdr  = 14'd0;
        cp         = 1'b0;
        lp         = 1'b0;
        flm        = 1'b0;
        frame_done = 1'b0;
        d          = d_reg;
        m          = m_reg;
        if (state == NIB) begin
            if (phase < 3'd4) begin
                pixelclk  = 1'b1;
                pixeladdr = line_base + col + {11'd0, phase};
            end
            cp = (phase >= 3'd6);
        end
        if (state == TAIL) begin
            lp         = (phase >= 3'd2) && (phase <= 3'd5);
            flm        = last_line;
            frame_done = last_line && (phase == 3'd7);
        end
    end
endmodule

// File: tb/tb_lcd_scan.sv
// tb/tb_lcd_scan.sv - directed self-checking bench for lcd_scan
`timescale 1ns/1ps
module tb_lcd_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        pixel = 1'b0;
    logic        pixelclk;
    logic [13:0] pixeladdr;
    logic [3:0]  d;
    logic        cp;
    logic        lp;
    logic        flm;
    logic        m;
    logic        frame_done;
    bit          fb [0:16383];
    int          checks = 0;
    int          errors = 0;

    lcd_scan dut (
        .clk(clk), .reset(reset), .en(en),
        .pixelclk(pixelclk), .pixeladdr(pixeladdr), .pixel(pixel),
        .d(d), .cp(cp), .lp(lp), .flm(flm), .m(m), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Memory hub: registered read, data valid the cycle after the address.
    always @(posedge clk) pixel <= fb[pixeladdr];

    function automatic logic [3:0] nib(input logic [3:0] v);
`ifdef LCD_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Reset, then enable; returns at the negedge of the first NIB cycle (index 0).
    task automatic start_run();
        @(negedge clk); reset = 1'b1; en = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk); reset = 1'b1; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pixelclk, pixeladdr, d, cp, lp, flm, m, frame_done} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000000", {pixelclk, pixeladdr, d, cp, lp, flm, m, frame_done});
        end
    endtask

    task automatic test_first_nibble();
        logic [13:0] exp_addr;
        logic [3:0]  exp_d;
        logic        exp_p;
        start_run();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            exp_p    = (c < 4);
            exp_addr = exp_p ? 14'(c) : 14'd0;
            exp_d    = (c >= 5) ? nib(4'b1000) : 4'b0000;
            checks++;
            if (pixelclk !== exp_p || pixeladdr !== exp_addr) begin
                errors++;
                $display("FAIL first_fetch phase %0d got pclk=%b addr=%0d want pclk=%b addr=%0d", c, pixelclk, pixeladdr, exp_p, exp_addr);
            end
            checks++;
            if (d !== exp_d) begin
                errors++;
                $display("FAIL first_d phase %0d got %b want %b", c, d, exp_d);
            end
            checks++;
            if (cp !== (c >= 6)) begin
                errors++;
                $display("FAIL first_cp phase %0d got %b want %b", c, cp, (c >= 6));
            end
        end
    endtask

    // Continues from phase 7 of nibble 0 of line 0.
    task automatic test_full_line();
        int   i = 7;
        int   falls = 0;
        int   lp_at = -1;
        logic prev_cp;
        prev_cp = cp;
        while (lp_at < 0 && i < 400) begin
            @(negedge clk); i++;
            if (prev_cp && !cp) falls++;
            prev_cp = cp;
            if (lp) lp_at = i;
        end
        checks++;
        if (falls != 40 || lp_at != 322) begin
            errors++;
            $display("FAIL line0_cp_falls got falls=%0d lp_at=%0d want falls=40 lp_at=322", falls, lp_at);
        end
        falls = 0;
        while (!pixelclk && i < 800) begin
            @(negedge clk); i++;
            if (prev_cp && !cp) falls++;
            prev_cp = cp;
        end
        checks++;
        if (i != 328 || pixeladdr !== 14'd160) begin
            errors++;
            $display("FAIL line1_start got cycle=%0d addr=%0d want cycle=328 addr=160", i, pixeladdr);
        end
        lp_at = -1;
        while (lp_at < 0 && i < 1000) begin
            @(negedge clk); i++;
            if (prev_cp && !cp) falls++;
            prev_cp = cp;
            if (lp) lp_at = i;
        end
        checks++;
        if (falls != 40 || lp_at != 650) begin
            errors++;
            $display("FAIL line1_cp_falls got falls=%0d lp_at=%0d want falls=40 lp_at=650", falls, lp_at);
        end
    endtask

    // Runs frame 1 and into frame 2 up to line 37 nibble 12 phase 2 (cycle 38474).
    task automatic test_full_frame();
        int          fd_first = -1;
        int          fd_cnt = 0;
        int          flm_first = -1;
        int          flm_cnt = 0;
        int          lpflm = 0;
        logic [13:0] max_addr = 14'd0;
        logic [13:0] a_last = 14'd0;
        logic [13:0] a_wrap = 14'd0;
        logic        p_wrap = 1'b0;
        logic        m_early = 1'b1;
        logic        m_late = 1'b0;
        start_run();
        for (int i = 0; i <= 38474; i++) begin
            if (i > 0) @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
            end
            if (flm) begin
                flm_cnt++;
                if (flm_first < 0) flm_first = i;
                if (lp) lpflm++;
            end
            if (pixelclk && pixeladdr > max_addr) max_addr = pixeladdr;
            if (i == 25912) a_last = pixeladdr;
            if (i == 26240) begin a_wrap = pixeladdr; p_wrap = pixelclk; end
            if (i == 100) m_early = m;
            if (i == 26300) m_late = m;
        end
        checks++;
        if (fd_first != 26239 || fd_cnt != 1) begin
            errors++;
            $display("FAIL frame_done_period got first=%0d count=%0d want first=26239 count=1", fd_first, fd_cnt);
        end
        checks++;
        if (flm_first != 26232 || flm_cnt != 8 || lpflm != 4) begin
            errors++;
            $display("FAIL flm_window got first=%0d count=%0d with_lp=%0d want 26232 8 4", flm_first, flm_cnt, lpflm);
        end
        checks++;
        if (max_addr !== 14'd12799 || a_last !== 14'd12640) begin
            errors++;
            $display("FAIL addr_range got max=%0d line79=%0d want max=12799 line79=12640", max_addr, a_last);
        end
        checks++;
        if (a_wrap !== 14'd0 || p_wrap !== 1'b1) begin
            errors++;
            $display("FAIL addr_wrap got addr=%0d pclk=%b want addr=0 pclk=1", a_wrap, p_wrap);
        end
        checks++;
        if (m_early !== 1'b0 || m_late !== 1'b1) begin
            errors++;
            $display("FAIL m_toggle got frame1=%b frame2=%b want 0 1", m_early, m_late);
        end
    endtask

    // Starts at cycle 38474: frame 2, line 37, nibble 12, phase 2.
    task automatic test_en_drop();
        checks++;
        if (pixelclk !== 1'b1 || pixeladdr !== 14'd5970 || d !== nib(4'b1010) || m !== 1'b1) begin
            errors++;
            $display("FAIL pre_drop got pclk=%b addr=%0d d=%b m=%b want 1 5970 %b 1", pixelclk, pixeladdr, d, m, nib(4'b1010));
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({pixelclk, pixeladdr, d, cp, lp, flm, frame_done} !== 23'h0 || m !== 1'b1) begin
                errors++;
                $display("FAIL en_drop_idle cycle %0d got %h m=%b want 000000 m=1", k, {pixelclk, pixeladdr, d, cp, lp, flm, frame_done}, m);
            end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (pixelclk !== 1'b1 || pixeladdr !== 14'd0) begin
            errors++;
            $display("FAIL reenable_addr got pclk=%b addr=%0d want pclk=1 addr=0", pixelclk, pixeladdr);
        end
    endtask

    // Starts at cycle 0 after re-enable; pulses reset at line 0 tail phase 2.
    task automatic test_reset_mid_tail();
        for (int i = 1; i <= 322; i++) @(negedge clk);
        checks++;
        if (lp !== 1'b1 || d !== nib(4'b0110) || m !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_tail got lp=%b d=%b m=%b want lp=1 d=%b m=1", lp, d, m, nib(4'b0110));
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({lp, flm, d, m, cp, pixelclk, frame_done} !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid_tail got lp=%b flm=%b d=%b m=%b cp=%b pclk=%b fd=%b want all 0", lp, flm, d, m, cp, pixelclk, frame_done);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pixelclk !== 1'b1 || pixeladdr !== 14'd0) begin
            errors++;
            $display("FAIL restart_after_reset got pclk=%b addr=%0d want pclk=1 addr=0", pixelclk, pixeladdr);
        end
    endtask

    // Starts at cycle 0 of a frame begun straight after reset (m cleared).
    task automatic test_frame_after_reset();
        int          fd_first = -1;
        int          fd_cnt = 0;
        logic        m_before = 1'b1;
        logic        m_after = 1'b0;
        logic [13:0] a_wrap = 14'h3fff;
        for (int i = 0; i <= 26290; i++) begin
            if (i > 0) @(negedge clk);
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
            end
            if (i == 26239) m_before = m;
            if (i == 26240) begin m_after = m; a_wrap = pixeladdr; end
        end
        checks++;
        if (fd_first != 26239 || fd_cnt != 1) begin
            errors++;
            $display("FAIL frame3_done got first=%0d count=%0d want first=26239 count=1", fd_first, fd_cnt);
        end
        checks++;
        if (m_before !== 1'b0 || m_after !== 1'b1 || a_wrap !== 14'd0) begin
            errors++;
            $display("FAIL frame3_m_wrap got m=%b->%b addr=%0d want 0->1 addr=0", m_before, m_after, a_wrap);
        end
    endtask

    initial begin
        // pixel 0 lit; line 0 last nibble 0110; line 37 nibble 11 1010
        fb[0]    = 1'b1;
        fb[157]  = 1'b1;
        fb[158]  = 1'b1;
        fb[5964] = 1'b1;
        fb[5966] = 1'b1;
        test_reset();
        test_first_nibble();
        test_full_line();
        test_full_frame();
        test_en_drop();
        test_reset_mid_tail();
        test_frame_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_scan.md
# lcd_scan

Display-side scan controller for the 160x80 monochrome framebuffer. It is the consumer of the memory hub's LCD bridge port: it drives `pixelclk`/`pixeladdr`, captures the returned `pixel` bit, packs pixels into nibbles, and drives a 4-bit STN-style LCD panel bus (`d`, `cp`, `lp`, `flm`, `m`). It also emits a one-cycle end-of-frame pulse that the interrupt logic can use.

## Interface
- `WIDTH`, default 160: pixels per line; multiple of 4.
- `HEIGHT`, default 80: lines per frame; `WIDTH*HEIGHT` ≤ 16384.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable, level.
- `pixelclk`  out  1  fetch strobe, high while `pixeladdr` carries a valid fetch.
- `pixeladdr`  out  14  linear pixel index, `line*WIDTH + x`.
- `pixel`  in  1  hub read data, valid the cycle after the address is presented.
- `d`  out  4  panel data; `d[3]` is the leftmost pixel of the nibble.
- `cp`  out  1  panel shift clock; the panel latches `d` on the falling edge.
- `lp`  out  1  line latch pulse.
- `flm`  out  1  first-line marker.
- `m`  out  1  LCD AC-drive alternation.
- `frame_done`  out  1  single-cycle pulse at the end of each frame.

## Operation
- States:
  - `IDLE`: all outputs 0 except `m`, which holds its value.
  - `NIB`: nibble slot of 8 clk, phase counter 0..7, nibble counter 0..WIDTH/4-1.
  - `TAIL`: line tail of 8 clk.
- Transitions:
  - IDLE → NIB when `en`=1 and not in reset. Start is line 0, nibble 0, phase 0.
  - NIB phase 7 of the last nibble → TAIL.
  - TAIL phase 7 → NIB of line+1. After line HEIGHT-1, the next line is line 0.
- Fetch, NIB phases 0..3:
  - `pixelclk`=1.
  - `pixeladdr` = `line*WIDTH + 4*nibble + phase`.
  - `pixeladdr`=0 and `pixelclk`=0 at all other times.
- Capture:
  - `pixel` is sampled at the end of phases 1..4 into shift bits 3..0.
  - At the end of phase 4 the 4 captured bits load `d`.
  - `d` stays stable until the end of phase 4 of the next nibble.
  - The last nibble's data holds through TAIL.
- `cp`=1 during NIB phases 6..7, 0 otherwise. Each falling edge occurs at least 1 clk after `d` updates.
- TAIL:
  - `cp`=0.
  - `lp`=1 during phases 2..5.
  - `flm`=1 during all 8 phases of the tail of line HEIGHT-1 only.
- End of frame, TAIL phase 7 of line HEIGHT-1:
  - `frame_done`=1 for that one cycle.
  - `m` toggles at the end of that cycle.
- Address arithmetic: a line base register is incremented by WIDTH. No multiplier is used. The address is unsigned 14-bit with no wrap inside a frame.
- `en` deasserted, any state: the next cycle is IDLE with all counters cleared. A partially shifted nibble is discarded. Re-enable always restarts at line 0, nibble 0.
- `reset`: the next cycle is IDLE with all outputs 0, including `m`. This holds mid-line and mid-nibble.
- `reset` takes priority over `en`.

## Timing
- Fetch-to-capture latency: 1 clk. The hub registers `pixel` from `pixeladdr` on the same `clk`.
- Nibble period: 8 clk.
- Line period: (WIDTH/4)*8 + 8 clk. With the defaults this is 328 clk.
- Frame period: HEIGHT × line period. With the defaults this is 26240 clk, about 140 Hz at 3.6864 MHz.
- First `pixelclk` after `en` rises: 1 clk later. This is the IDLE→NIB transition cycle.
- First `cp` rise: phase 6 of nibble 0, which is 7 clk after leaving IDLE.
- All outputs are registered. None are combinational from inputs.

## Configuration
- `LCD_INVERT_EN`:
  - Defined: `d` is loaded with the bitwise inverse of the captured bits, so a framebuffer 0 drives a dark pixel. `IDLE` still drives `d`=0.
  - Undefined: captured bits are passed through unchanged.

## Test plan
- Reset then `en`=1, framebuffer all zero except pixel 0 = 1:
  - First nibble drives `d`=4'b1000 at phase 5.
  - `cp` is high in cycles 6..7.
  - `pixeladdr` sequence is 0,1,2,3.
- Full line check: count of `cp` falling edges between `lp` pulses is 40. `pixeladdr` at line 1 nibble 0 phase 0 is 160.
- Full frame check:
  - `frame_done` pulses every 26240 clk.
  - `flm`=1 only in the tail of line 79, coinciding with that `lp`.
  - `m` alternates 0,1,0 across 3 frames.
- Wrap: after line 79 the next fetch address is 0, and the maximum address seen is 12799.
- `en` dropped at line 37 nibble 12 phase 2:
  - Next cycle all outputs are 0 and `m` is held.
  - On re-enable, the first address is 0.
- `reset` pulsed mid-TAIL with `lp`=1: `lp`, `flm`, `d` and `m` go to 0 the next cycle. With `LCD_INVERT_EN` defined, the all-zero framebuffer gives `d`=4'b1111.
